messbauer_spectrum_memory_arbiter: RTL and testbench

Sequences and shares the single-port spectrum RAM of the Mossbauer CAMAC accumulator. Three users contend for it: the accumulation engine, which issues channel-increment requests in autonomous and amplitude-analysis modes; the CAMAC host path, which performs F(0) reads and F(16) writes at a given address; and a full-memory clear sequence. Increments are done as read-modify-write with saturation. The block sits between the accumulator mode/address logic and the RAM.

---
 rtl/messbauer_spectrum_memory_arbiter.sv | 174 +++++++++++++++++
 tb/tb_messbauer_spectrum_memory_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/messbauer_spectrum_memory_arbiter.sv
// ---------------------------------------------------------------------------
// messbauer_spectrum_memory_arbiter
//
// Shares the single-port spectrum RAM of the Mossbauer accumulator between:
//   - the accumulation engine (saturating read-modify-write channel increments)
//   - the CAMAC host path (F(0) reads / F(16) writes)
//   - a full-memory clear sequence
//
// Ports:
//   clk, rst                   system clock, synchronous active-high reset
//   inc_valid/inc_addr         increment request; accepted on inc_valid & inc_ready
//   inc_ready                  increment may be accepted this cycle
//   host_req/host_we           host access request (level, held until host_ack)
//   host_addr/host_wdata       host address and write data
//   host_ack                   one-cycle host completion pulse
//   host_rdata                 host read data, valid with host_ack, held after
//   clr_start                  pulse: clear the whole memory
//   clr_busy                   clear pending or running
//   sat_flag                   sticky: an increment hit a saturated channel
//   mem_addr/mem_we/mem_wdata  RAM command, decoded from state and latched regs
//   mem_rdata                  RAM read data, one cycle after a read address
// ---------------------------------------------------------------------------
module messbauer_spectrum_memory_arbiter #(
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 24,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inc_valid,
   input  logic [ADDR_WIDTH-1:0] inc_addr,
   output logic                  inc_ready,
   input  logic                  host_req,
   input  logic                  host_we,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0] host_wdata,
   output logic                  host_ack,
   output logic [DATA_WIDTH-1:0] host_rdata,
   input  logic                  clr_start,
   output logic                  clr_busy,
   output logic                  sat_flag,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INC_RD, S_INC_WR, S_HOST_RD, S_HOST_DONE, S_HOST_WR, S_CLEAR
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;        // increment/host address, or clear pointer
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_host_rdata;
   logic                  r_clr_pend;
   logic [CNT_W-1:0]      r_starve_cnt;
   logic                  r_sat;

   logic w_force_host, w_grant_clr, w_grant_inc, w_grant_host;
   logic w_rd_full, w_last_clr;

   // A host that has watched STARVE_LIMIT increments go ahead of it wins next.
   assign w_force_host = host_req && (r_starve_cnt >= CNT_W'(STARVE_LIMIT));
   assign w_grant_clr  = (r_state == S_IDLE) && r_clr_pend;
   assign w_grant_inc  = (r_state == S_IDLE) && !r_clr_pend && !w_force_host && inc_valid;
   assign w_grant_host = (r_state == S_IDLE) && !r_clr_pend && host_req
                         && (w_force_host || !inc_valid);
   assign w_rd_full    = &mem_rdata;
   assign w_last_clr   = &r_addr;

   // NOTE: every signal written here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_grant_clr)       w_state_nxt = S_CLEAR;
            else if (w_grant_inc)  w_state_nxt = S_INC_RD;
            else if (w_grant_host) w_state_nxt = host_we ? S_HOST_WR : S_HOST_RD;
         end
         S_INC_RD:    w_state_nxt = S_INC_WR;
         S_INC_WR:    w_state_nxt = S_IDLE;
         S_HOST_RD:   w_state_nxt = S_HOST_DONE;
         S_HOST_DONE: w_state_nxt = S_IDLE;
         S_HOST_WR:   w_state_nxt = S_IDLE;
         S_CLEAR:     if (w_last_clr) w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs. Reset forces everything low, which also suppresses a RAM write
   // that would otherwise land on the same edge the reset is sampled.
   always_comb begin
      inc_ready  = 1'b0;
      host_ack   = 1'b0;
      host_rdata = '0;
      clr_busy   = 1'b0;
      sat_flag   = 1'b0;
      mem_addr   = '0;
      mem_we     = 1'b0;
      mem_wdata  = '0;
      if (!rst) begin
         inc_ready  = (r_state == S_IDLE) && !r_clr_pend && !w_force_host;
         clr_busy   = r_clr_pend || (r_state == S_CLEAR);
         sat_flag   = r_sat;
         mem_addr   = r_addr;
         host_rdata = r_host_rdata;
         unique case (r_state)
            S_INC_WR: begin
               mem_we    = 1'b1;
               mem_wdata = w_rd_full ? mem_rdata : mem_rdata + DATA_WIDTH'(1);
            end
            S_HOST_WR: begin
               mem_we    = 1'b1;
               mem_wdata = r_wdata;
               host_ack  = 1'b1;
            end
            S_HOST_DONE: begin
               // RAM data arrives this cycle; bypass it so it is valid with the ack.
               host_ack   = 1'b1;
               host_rdata = mem_rdata;
            end
            S_CLEAR: mem_we = 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_host_rdata <= '0;
         r_clr_pend   <= 1'b0;
         r_starve_cnt <= '0;
         r_sat        <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if (clr_start && (r_state != S_CLEAR)) r_clr_pend <= 1'b1;

         if (w_grant_clr) begin
            // Starting the clear absorbs any pending request.
            r_clr_pend <= 1'b0;
            r_addr     <= '0;
            r_sat      <= 1'b0;
         end else if (w_grant_inc) begin
            r_addr <= inc_addr;
         end else if (w_grant_host) begin
            r_addr  <= host_addr;
            r_wdata <= host_wdata;
         end else if (r_state == S_CLEAR) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
         end

         if (w_grant_host)
            r_starve_cnt <= '0;
         else if (w_grant_inc && host_req) begin
            if (r_starve_cnt < CNT_W'(STARVE_LIMIT)) r_starve_cnt <= r_starve_cnt + CNT_W'(1);
         end else if ((r_state == S_IDLE) && !host_req)
            r_starve_cnt <= '0;

         if ((r_state == S_INC_WR) && w_rd_full) r_sat <= 1'b1;
         if (r_state == S_HOST_DONE)             r_host_rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_messbauer_spectrum_memory_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for messbauer_spectrum_memory_arbiter. A behavioural RAM sits on
// the mem_* port; a reference array of channel counts predicts host reads,
// which a monitor checks against a scoreboard queue as host_ack appears.
// ---------------------------------------------------------------------------
module tb_messbauer_spectrum_memory_arbiter;

   localparam int AW    = 12;
   localparam int DW    = 24;
   localparam int SL    = 4;
   localparam int DEPTH = 1 << AW;
   localparam logic [DW-1:0] FULL = {DW{1'b1}};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          inc_valid = 1'b0;
   logic [AW-1:0] inc_addr = '0;
   logic          inc_ready;
   logic          host_req = 1'b0;
   logic          host_we = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] host_wdata = '0;
   logic          host_ack;
   logic [DW-1:0] host_rdata;
   logic          clr_start = 1'b0;
   logic          clr_busy;
   logic          sat_flag;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   always #5 clk = ~clk;

   messbauer_spectrum_memory_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)
   ) dut (
      .clk(clk), .rst(rst),
      .inc_valid(inc_valid), .inc_addr(inc_addr), .inc_ready(inc_ready),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
      .clr_start(clr_start), .clr_busy(clr_busy), .sat_flag(sat_flag),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Synchronous single-port RAM, read data one cycle after the address.
   logic [DW-1:0] ram [DEPTH];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: channel counts and the sticky saturation indication.
   logic [DW-1:0] ref_mem [DEPTH];
   bit            ref_sat;

   function automatic logic [DW-1:0] model_inc(input logic [DW-1:0] v);
      longint top = (longint'(1) << DW) - 1;
      longint nv  = longint'(v) + 1;
      if (nv > top) nv = top;
      return DW'(nv);
   endfunction

   typedef struct {
      bit            is_rd;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   inc_log[$];
   int   cyc = 0;
   int   starve_seen = 0;
   bit   starve_chk = 0;
   int   viol = 0;
   int   busy_cycles = 0;
   int   clr_ok = 0;
   logic [AW-1:0] clr_exp_addr = '0;
   int   we_cnt = 0;

   always @(posedge clk) cyc++;
   always @(negedge clk) if (mem_we) we_cnt++;

   // Monitor: applies accepted increments to the model, checks host responses.
   always @(negedge clk) begin
      if (!rst) begin
         if (inc_valid && inc_ready) begin
            if (ref_mem[inc_addr] == FULL) ref_sat = 1'b1;
            ref_mem[inc_addr] = model_inc(ref_mem[inc_addr]);
            inc_log.push_back(cyc);
            if (host_req) starve_seen++;
         end
         if (host_ack) begin
            if (sb.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
            else begin
               exp_t e;
               e = sb.pop_front();
               if (e.is_rd) check($sformatf("host_rd[%0h]", e.addr), host_rdata, e.data);
            end
            if (starve_chk) begin
               check("starve_grants", starve_seen, SL);
               starve_chk = 0;
            end
            if (clr_busy) viol++;
         end
         if (clr_busy && inc_ready) viol++;
         if (clr_busy) busy_cycles++;
         if (clr_busy && mem_we) begin
            if (mem_addr == clr_exp_addr && mem_wdata == '0) clr_ok++;
            clr_exp_addr++;
         end
      end
   end

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Holds inc_valid until n increments are accepted (one cycle per loop).
   task automatic inc_burst(input logic [AW-1:0] a, input int n);
      int got = 0;
      int guard = 0;
      inc_addr  = a;
      inc_valid = 1'b1;
      while (got < n && guard < 200) begin
         @(negedge clk);
         guard++;
         if (inc_ready) got++;
         @(posedge clk);
         #1;
      end
      inc_valid = 1'b0;
      if (got < n) check("inc_timeout", got, n);
   endtask

   task automatic host_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      int   guard = 0;
      e.is_rd = !we;
      e.addr  = a;
      e.data  = we ? d : ref_mem[a];
      sb.push_back(e);
      if (we) ref_mem[a] = d;
      host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1;
      do begin
         @(negedge clk);
         guard++;
      end while (!host_ack && guard < 20000);
      if (!host_ack) check("host_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 host_req = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_inc_ready"}, inc_ready, 0);
      check({tag, "_host_ack"}, host_ack, 0);
      check({tag, "_host_rdata"}, host_rdata, 0);
      check({tag, "_clr_busy"}, clr_busy, 0);
      check({tag, "_sat_flag"}, sat_flag, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      logic [DW-1:0] saved;
      for (int i = 0; i < DEPTH; i++) begin
         ram[i]     = '0;
         ref_mem[i] = '0;
      end
      ref_sat = 0;

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("idle_inc_ready", inc_ready, 1);
      @(posedge clk);
      #1;

      // Three back-to-back increments to one channel, one per 3 cycles.
      inc_log.delete();
      inc_burst(12'h005, 3);
      check("inc_gap0", inc_log[1] - inc_log[0], 3);
      check("inc_gap1", inc_log[2] - inc_log[1], 3);
      settle(3);
      host_op(0, 12'h005, '0);

      // Saturation: 0xFFFFFE + 2 stays at all-ones and sets the flag.
      host_op(1, 12'h00A, 24'hFFFFFE);
      inc_burst(12'h00A, 2);
      settle(3);
      host_op(0, 12'h00A, '0);
      check("sat_flag_set", sat_flag, ref_sat);
      check("ram_sat_value", ram[12'h00A], ref_mem[12'h00A]);

      // Starvation: increments held, host forced in after SL grants.
      inc_addr = 12'h100;
      inc_valid = 1'b1;
      starve_seen = 0;
      starve_chk = 1;
      host_op(0, 12'h005, '0);
      n0 = inc_log.size();
      settle(12);
      check("inc_resume", inc_log.size() - n0, 4);
      inc_valid = 1'b0;
      settle(3);
      host_op(0, 12'h100, '0);

      // Clear requested while an increment is in its write cycle.
      host_op(1, 12'h000, 24'h00ABCD);
      host_op(1, 12'hFFF, 24'h123456);
      inc_addr = 12'h005;
      inc_valid = 1'b1;
      begin
         int g = 0;
         do begin @(negedge clk); g++; end while (!inc_ready && g < 50);
      end
      @(posedge clk);
      #1 inc_valid = 1'b0;
      @(posedge clk);
      #1 clr_start = 1'b1;
      @(posedge clk);
      #1 clr_start = 1'b0;
      check("inc_done_before_clear", ram[12'h005], ref_mem[12'h005]);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      ref_sat = 0;
      viol = 0; busy_cycles = 0; clr_ok = 0; clr_exp_addr = '0;
      settle(100);
      host_op(0, 12'h005, '0);       // raised mid-clear, served after it
      check("clear_protocol", viol, 0);
      check("clr_busy_cycles", busy_cycles, DEPTH + 1);
      check("clr_writes", clr_ok, DEPTH);
      host_op(0, 12'h000, '0);
      host_op(0, 12'hFFF, '0);
      check("sat_after_clear", sat_flag, ref_sat);

      // Reset during an increment's read cycle: no write, channel unchanged.
      host_op(1, 12'h031, FULL);
      inc_burst(12'h031, 1);
      settle(3);
      host_op(1, 12'h030, 24'h000123);
      host_op(0, 12'h030, '0);
      saved = ref_mem[12'h040];
      inc_addr = 12'h040;
      inc_valid = 1'b1;
      begin
         int g = 0;
         do begin @(negedge clk); g++; end while (!inc_ready && g < 50);
      end
      @(posedge clk);
      #1 inc_valid = 1'b0;
      rst = 1'b1;
      we_cnt = 0;
      @(posedge clk);
      @(negedge clk);
      check_zero("rst_mid");
      @(posedge clk);
      #1 rst = 1'b0;
      settle(3);
      check("rst_no_write", we_cnt, 0);
      check("rst_ram_kept", ram[12'h040], saved);
      ref_mem[12'h040] = saved;      // the aborted increment never happened
      ref_sat = 0;
      host_op(0, 12'h040, '0);

      // Randomized mix on a small address window to force collisions.
      for (int it = 0; it < 40; it++) begin
         int            r;
         logic [AW-1:0] a;
         r = $urandom_range(0, 9);
         a = AW'(12'h020 + $urandom_range(0, 5));
         if (r < 5) begin
            inc_burst(a, $urandom_range(1, 3));
            settle($urandom_range(0, 2));
         end else if (r < 7) begin
            if ($urandom_range(0, 1) == 0) host_op(1, a, DW'($urandom));
            else host_op(1, a, FULL - DW'($urandom_range(0, 2)));
         end else begin
            host_op(0, a, '0);
         end
      end
      settle(4);
      for (int i = 12'h020; i <= 12'h025; i++)
         check($sformatf("final_ram[%0h]", i), ram[i], ref_mem[i]);
      check("final_sat", sat_flag, ref_sat);
      check("scoreboard_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
